// File: rtl/barrel_hit_ctrl.sv
// Barrel collision and jump-over controller: tracks lives, post-hit immunity,
// game-over state and a saturating jump-over score for one barrel.
module barrel_hit_ctrl #(
    parameter logic [9:0]  MARIO_W       = 10'd26,
    parameter logic [8:0]  MARIO_H       = 9'd32,
    parameter logic [1:0]  LIVES_INIT    = 2'd3,
    parameter logic [7:0]  INVULN_CYCLES = 8'd120,
    parameter logic [8:0]  JUMP_ZONE     = 9'd40,
    parameter logic [15:0] JUMP_POINTS   = 16'd100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [9:0]  barrel_x,
    input  logic [8:0]  barrel_y,
    input  logic [1:0]  barrel_state,
    input  logic [9:0]  mario_x,
    input  logic [8:0]  mario_y,
    output logic        over,
    output logic        hit,
    output logic [1:0]  lives,
    output logic [15:0] score
);

    typedef enum logic [1:0] {StIdle, StPlay, StHit, StOver} state_e;

    state_e     state_q;
    logic [7:0] timer_q;
    logic       scored_q;

    logic        rolling, active;
    logic [9:0]  barrel_w;
    logic [8:0]  barrel_h;
    logic [10:0] barrel_right, mario_right;
    logic [9:0]  barrel_bottom, mario_bottom;
    logic        x_overlap, overlap, above, jump_ok;
    logic [16:0] score_sum;
    logic [15:0] score_sat;

    // Edge sums are one bit wider than the operands so they never wrap.
    always_comb begin
        rolling       = (barrel_state == 2'b01);
        active        = rolling || (barrel_state == 2'b10);
        barrel_w      = (barrel_state == 2'b10) ? 10'd42 : 10'd32;
        barrel_h      = 9'd24;
        barrel_right  = {1'b0, barrel_x} + {1'b0, barrel_w};
        mario_right   = {1'b0, mario_x} + {1'b0, MARIO_W};
        barrel_bottom = {1'b0, barrel_y} + {1'b0, barrel_h};
        mario_bottom  = {1'b0, mario_y} + {1'b0, MARIO_H};
        x_overlap     = active && ({1'b0, mario_x} < barrel_right)
                        && (mario_right > {1'b0, barrel_x});
        overlap       = x_overlap && ({1'b0, mario_y} < barrel_bottom)
                        && (mario_bottom > {1'b0, barrel_y});
        above         = (mario_bottom <= {1'b0, barrel_y})
                        && (({1'b0, barrel_y} - mario_bottom) < {1'b0, JUMP_ZONE});
        jump_ok       = rolling && x_overlap && above && !overlap && !scored_q;
        score_sum     = {1'b0, score} + {1'b0, JUMP_POINTS};
        score_sat     = score_sum[16] ? 16'hFFFF : score_sum[15:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            timer_q  <= 8'd0;
            scored_q <= 1'b0;
            lives    <= 2'd0;
            score    <= 16'd0;
            hit      <= 1'b0;
            over     <= 1'b0;
        end else begin
            hit <= 1'b0;
            if (!x_overlap) scored_q <= 1'b0;
            unique case (state_q)
                StIdle, StOver: begin
                    if (start) begin
                        state_q  <= StPlay;
                        lives    <= LIVES_INIT;
                        score    <= 16'd0;
                        scored_q <= 1'b0;
                        over     <= 1'b0;
                    end
                end
                StPlay: begin
                    if (overlap) begin
                        hit   <= 1'b1;
                        lives <= lives - 2'd1;
                        if (lives == 2'd1) begin
                            state_q <= StOver;
                            over    <= 1'b1;
                        end else begin
                            state_q <= StHit;
                            timer_q <= INVULN_CYCLES;
                        end
                    end else if (jump_ok) begin
                        score    <= score_sat;
                        scored_q <= 1'b1;
                    end
                end
                StHit: begin
                    timer_q <= timer_q - 8'd1;
                    if (timer_q == 8'd1) state_q <= StPlay;
                    if (jump_ok) begin
                        score    <= score_sat;
                        scored_q <= 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
